// File: rtl/imem_loader.sv
// imem_loader: streams bytes into 21-bit words, writes them to imem from address 0, and releases the core only on a good XOR checksum
module imem_loader #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    word_count,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;
  logic [2:0]         state;
  logic [ADDR_W:0]    cnt;
  logic [ADDR_W:0]    wc;
  logic [1:0]         bidx;
  logic [7:0]         acc;
  logic [INSTR_W-1:0] wbuf;
  // every output is a decode of state or a register, so in_valid never reaches in_ready combinationally
  assign in_ready   = (state == LOAD) || (state == CHECK);
  assign imem_we    = state == WRITE;
  assign imem_addr  = cnt[ADDR_W-1:0];
  assign imem_wdata = wbuf;
  assign core_hold  = state != DONE;
  assign busy       = (state == LOAD) || (state == WRITE) || (state == CHECK);
  assign done       = state == DONE;
  assign error      = state == ERR;
  // load sequencer: byte assembly, checksum accumulation, address stepping and final verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      wc    <= '0;
      bidx  <= '0;
      acc   <= '0;
      wbuf  <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          wc    <= word_count;
          cnt   <= '0;
          bidx  <= '0;
          acc   <= '0;
          state <= word_count == '0 ? CHECK : LOAD;
        end
        LOAD: if (in_valid) begin
          acc   <= acc ^ in_data;
          bidx  <= bidx == 2'd2 ? 2'd0 : bidx + 2'd1;
          state <= bidx == 2'd2 ? WRITE : LOAD;
          if (bidx == 2'd0) wbuf[7:0] <= in_data;
          if (bidx == 2'd1) wbuf[15:8] <= in_data;
          if (bidx == 2'd2) wbuf[INSTR_W-1:16] <= in_data[INSTR_W-17:0];
        end
        WRITE: begin
          cnt   <= cnt + 1'b1;
          state <= cnt == wc - 1'b1 ? CHECK : LOAD;
        end
        CHECK: if (in_valid) state <= in_data == acc ? DONE : ERR;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory program loader for the AES SIMD pipeline. It accepts a byte stream on a valid/ready handshake, assembles 21-bit instruction words, and writes them sequentially into instruction memory from address 0. It holds the pipeline core in reset while loading, verifies a trailing XOR checksum, and releases the core only on success. It is the writer for the instruction memory that the fetch stage reads.

## Interface
- ADDR_W, 12, instruction-memory address width (matches fetch PC width)
- INSTR_W, 21, instruction word width; must be in 17..24 (3 bytes per word)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle load request; honoured only in IDLE or DONE
- word_count  in  ADDR_W+1  number of instruction words to load, 0..2^ADDR_W; sampled on the accepted start
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write enable, single-cycle pulse
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  INSTR_W  write data
- core_hold  out  1  active-high hold-in-reset request to the pipeline
- busy  out  1  high in LOAD, WRITE and CHECK
- done  out  1  high in DONE
- error  out  1  high in ERR (checksum mismatch)

## Operation
- States: IDLE, LOAD, WRITE, CHECK, DONE, ERR.
- IDLE, on start: latch word_count, clear the address counter, byte index and checksum accumulator.
  - Go to LOAD if word_count != 0.
  - Go directly to CHECK if word_count == 0; the expected checksum is then 0x00.
- LOAD: in_ready=1. A byte is accepted when in_valid && in_ready.
  - Bytes arrive little-endian: byte0 -> bits[7:0], byte1 -> [15:8], byte2 -> [INSTR_W-1:16]. Excess high bits of byte2 are ignored but still enter the checksum.
  - Every accepted byte is XORed into the 8-bit accumulator.
  - The third accepted byte moves the FSM to WRITE.
- WRITE: one cycle. imem_we=1, imem_addr=current counter, imem_wdata=assembled word, in_ready=0.
  - Then increment the counter.
  - If the written word was number word_count (counter == word_count-1), go to CHECK; otherwise go to LOAD with byte index 0.
- CHECK: in_ready=1. On the accepted byte, compare it with the accumulator.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- DONE: core_hold=0, done=1. A start is accepted and re-enters the load exactly as from IDLE; core_hold rises in the same edge.
- ERR: core_hold=1, error=1, in_ready=0. The only exit is rst. start is ignored.
- A start in LOAD, WRITE or CHECK is ignored.
- in_valid without in_ready: the byte is not consumed and the source must hold it.
- Address counter width is ADDR_W+1, so word_count=2^ADDR_W writes addresses 0..2^ADDR_W-1 with no wrap. imem_addr is the low ADDR_W bits.
- core_hold=1 in every state except DONE.

## Timing
- Reset values (asynchronous, while rst=0): state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, error=0, accumulator=0, counters=0.
- rst asserted mid-load aborts immediately to IDLE. Words already written stay in memory; nothing further is written.
- Outputs are registered or derived from state only; no combinational path from in_valid to in_ready.
- start accepted at edge N: busy=1 and in_ready=1 from cycle N+1 (or CHECK in cycle N+1 when word_count=0).
- The third byte of a word accepted at edge M: imem_we=1 during cycle M+1, in_ready=0 during cycle M+1, in_ready=1 again at M+2.
- Peak throughput is 3 bytes per 4 cycles; a full load takes 4*word_count + 1 cycles plus source stalls.
- Checksum byte accepted at edge K: done=1 (or error=1) and the core_hold change are visible from cycle K+1.

## Test plan
- Reset: drive rst=0 mid-LOAD -> all outputs return to reset values asynchronously; after release the FSM is in IDLE with core_hold=1 and no further imem_we.
- Two-word load: word_count=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66, then checksum 0x77 -> writes addr0=0x132211 and addr1=0x064455 (masked to 21 bits); done=1, core_hold=0.
- Checksum error: the same stream with checksum 0x00 -> no writes beyond the two words; error=1, core_hold=1; start is ignored until rst.
- Back-pressure: in_valid held high throughout -> in_ready drops only in each WRITE cycle; exactly one imem_we per 3 bytes; in_valid gaps of random length produce identical memory contents.
- Zero and full counts: word_count=0 with checksum 0x00 -> done after one byte and no imem_we. word_count=4096 -> last write at addr 0xFFF, no wrap to 0.
- Reload: start while in DONE -> core_hold rises at the next edge and a new load overwrites from address 0. start during LOAD is ignored.
